// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin
// selection and the value of each coin in 5-cent units.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SODA,
        PLAN,
        EJECT,
        WAIT_ACK,
        JAM
    } disp_state_e;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_NICKLE,
        COIN_DIME
    } coin_sel_e;

    localparam logic [2:0] NICKLE_UNITS = 3'd1;
    localparam logic [2:0] DIME_UNITS   = 3'd2;

    // Value of a coin in 5-cent units; COIN_NONE is worth nothing.
    function automatic logic [2:0] coin_units(input coin_sel_e c);
        logic [2:0] u;
        u = 3'd0;
        case (c)
            COIN_NICKLE: u = NICKLE_UNITS;
            COIN_DIME:   u = DIME_UNITS;
            default:     u = 3'd0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/eject_timer.sv
// Ejector timing for one coin: holds the pulse for PULSE_CYC cycles after
// start, then waits up to TIMEOUT_CYC cycles for the hopper acknowledge.
// done marks the last pulse cycle; timeout marks the last wait cycle with
// no acknowledge present.
module eject_timer
    import vend_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    input  logic ack,
    output logic pulse,
    output logic done,
    output logic timeout
);

    localparam int PW = (PULSE_CYC   > 1) ? $clog2(PULSE_CYC)   : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [PW-1:0] pulse_cnt;
    logic [TW-1:0] wait_cnt;
    logic          waiting;

    assign done    = pulse && (pulse_cnt == PW'(PULSE_CYC - 1));
    assign timeout = waiting && !ack && (wait_cnt == TW'(TIMEOUT_CYC - 1));

    // Pulse-width count, then acknowledge-timeout count; ack is only seen while waiting.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pulse     <= 1'b0;
            pulse_cnt <= '0;
            waiting   <= 1'b0;
            wait_cnt  <= '0;
        end else if (start) begin
            pulse     <= 1'b1;
            pulse_cnt <= '0;
            waiting   <= 1'b0;
        end else if (pulse) begin
            if (done) begin
                pulse    <= 1'b0;
                waiting  <= 1'b1;
                wait_cnt <= '0;
            end else begin
                pulse_cnt <= pulse_cnt + 1'b1;
            end
        end else if (waiting) begin
            if (ack || timeout) begin
                waiting <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Dispense side of the vending path: accepts a vend (soda flag + change in
// 5-cent units), strobes the soda release, then pays change greedily with
// dimes first, one coin per ejector pulse, tracking hopper inventory and
// flagging short-change and jams.
// Optional build macro VEND_STATS_EN adds vend/short statistics counters.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int NICKLE_INIT = 15,
    parameter int DIME_INIT   = 15,
    parameter int CNT_W       = 4,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vend_valid_i,
    output logic             vend_ready_o,
    input  logic             soda_i,
    input  logic [2:0]       change_i,
    output logic             soda_rel_o,
    output logic             nickle_eject_o,
    output logic             dime_eject_o,
    input  logic             coin_ack_i,
    input  logic             refill_i,
    output logic [CNT_W-1:0] nickle_cnt_o,
    output logic [CNT_W-1:0] dime_cnt_o,
    output logic             short_o,
    output logic             jam_o
`ifdef VEND_STATS_EN
    ,
    output logic [15:0]      vend_cnt_o,
    output logic [7:0]       short_cnt_o
`endif
);

    disp_state_e state;
    coin_sel_e   sel;
    coin_sel_e   pick;
    logic [2:0]  rem;
    logic        t_start;
    logic        t_pulse;
    logic        t_done;
    logic        t_timeout;
    logic        accept;
    logic        short_evt;

    // Greedy coin choice for the PLAN state: dime when at least 10 cents owed.
    always_comb begin
        pick = COIN_NONE;
        if (rem >= DIME_UNITS && dime_cnt_o != '0) begin
            pick = COIN_DIME;
        end else if (rem >= NICKLE_UNITS && nickle_cnt_o != '0) begin
            pick = COIN_NICKLE;
        end
    end

    assign accept    = (state == IDLE) && vend_valid_i;
    assign t_start   = (state == PLAN) && (pick != COIN_NONE);
    assign short_evt = (state == PLAN) && (pick == COIN_NONE) && (rem != 3'd0);

    eject_timer #(
        .PULSE_CYC   (PULSE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (t_start),
        .ack     (coin_ack_i),
        .pulse   (t_pulse),
        .done    (t_done),
        .timeout (t_timeout)
    );

    // Both terms are flops, so the drives stay glitch-free and drop with reset.
    assign nickle_eject_o = t_pulse && (sel == COIN_NICKLE);
    assign dime_eject_o   = t_pulse && (sel == COIN_DIME);

    // Dispenser FSM with inventory, flags and handshake outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            sel          <= COIN_NONE;
            vend_ready_o <= 1'b1;
            soda_rel_o   <= 1'b0;
            short_o      <= 1'b0;
            jam_o        <= 1'b0;
            nickle_cnt_o <= CNT_W'(NICKLE_INIT);
            dime_cnt_o   <= CNT_W'(DIME_INIT);
        end else begin
            soda_rel_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (refill_i) begin
                        nickle_cnt_o <= CNT_W'(NICKLE_INIT);
                        dime_cnt_o   <= CNT_W'(DIME_INIT);
                        jam_o        <= 1'b0;
                    end
                    if (vend_valid_i) begin
                        state        <= SODA;
                        vend_ready_o <= 1'b0;
                        soda_rel_o   <= soda_i;
                        short_o      <= 1'b0;
                    end
                end
                SODA: begin
                    state <= PLAN;
                end
                PLAN: begin
                    if (pick != COIN_NONE) begin
                        sel   <= pick;
                        state <= EJECT;
                    end else begin
                        if (rem != 3'd0) begin
                            short_o <= 1'b1;
                        end
                        state        <= IDLE;
                        vend_ready_o <= 1'b1;
                    end
                end
                EJECT: begin
                    if (t_done) begin
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (coin_ack_i) begin
                        if (sel == COIN_DIME) begin
                            dime_cnt_o <= dime_cnt_o - 1'b1;
                        end else if (sel == COIN_NICKLE) begin
                            nickle_cnt_o <= nickle_cnt_o - 1'b1;
                        end
                        sel   <= COIN_NONE;
                        state <= PLAN;
                    end else if (t_timeout) begin
                        sel   <= COIN_NONE;
                        jam_o <= 1'b1;
                        state <= JAM;
                    end
                end
                JAM: begin
                    if (refill_i) begin
                        nickle_cnt_o <= CNT_W'(NICKLE_INIT);
                        dime_cnt_o   <= CNT_W'(DIME_INIT);
                        jam_o        <= 1'b0;
                        state        <= IDLE;
                        vend_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    sel          <= COIN_NONE;
                    vend_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Change still owed: loaded on accept, reduced by each acknowledged coin.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rem <= change_i;
        end else if (state == WAIT_ACK && coin_ack_i) begin
            rem <= rem - coin_units(sel);
        end
    end

`ifdef VEND_STATS_EN
    // Saturating statistics: soda vends accepted and short-paid transactions.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vend_cnt_o  <= '0;
            short_cnt_o <= '0;
        end else begin
            if (accept && soda_i && vend_cnt_o != 16'hFFFF) begin
                vend_cnt_o <= vend_cnt_o + 1'b1;
            end
            if (short_evt && short_cnt_o != 8'hFF) begin
                short_cnt_o <= short_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule
